// File: rtl/fpu_ss_wb_arbiter.sv
// Writeback arbiter: round-robin merge of FPU results and FP load results into one result/regfile port.
// Latency: 1 cycle (accept in N -> x_result/fpr write/fflags strobe in N+1).
// Backpressure: a held x_result (valid & !ready) blocks both sources; fpr/fflags strobes never stall.
//
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   fpu_*                         fpnew result with tag (rd, rd_is_fp, id) and status flags
//   mem_*                         FP load result (data, rd, id, bus error)
//   fpr_we_o/waddr_o/wdata_o      FP register file write port (single-cycle pulse)
//   fflags_we_o/fflags_o          fflags accumulate strobe (single-cycle pulse)
//   x_result_*                    cv-x-if result channel (valid/ready, held stable while stalled)
//   busy_o                        any input pending or output stage occupied
module fpu_ss_wb_arbiter #(
  parameter int ID_WIDTH   = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,

  input  logic                  fpu_valid_i,
  output logic                  fpu_ready_o,
  input  logic [DATA_WIDTH-1:0] fpu_result_i,
  input  logic [4:0]            fpu_status_i,
  input  logic [4:0]            fpu_rd_i,
  input  logic                  fpu_rd_is_fp_i,
  input  logic [ID_WIDTH-1:0]   fpu_id_i,

  input  logic                  mem_valid_i,
  output logic                  mem_ready_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  input  logic [4:0]            mem_rd_i,
  input  logic [ID_WIDTH-1:0]   mem_id_i,
  input  logic                  mem_err_i,

  output logic                  fpr_we_o,
  output logic [4:0]            fpr_waddr_o,
  output logic [DATA_WIDTH-1:0] fpr_wdata_o,

  output logic                  fflags_we_o,
  output logic [4:0]            fflags_o,

  output logic                  x_result_valid_o,
  input  logic                  x_result_ready_i,
  output logic [ID_WIDTH-1:0]   x_result_id_o,
  output logic [DATA_WIDTH-1:0] x_result_data_o,
  output logic [4:0]            x_result_rd_o,
  output logic                  x_result_we_o,
  output logic                  x_result_exc_o,
  output logic [5:0]            x_result_exccode_o,

  output logic                  busy_o
);

  // Exception code reported for a load that returned a bus error.
  localparam logic [5:0] EXCCODE_LOAD_ACCESS_FAULT = 6'd5;

  // Which source won the most recent grant; reset to FPU so the first
  // contention goes to the memory path.
  typedef enum logic {
    SRC_FPU = 1'b0,
    SRC_MEM = 1'b1
  } src_e;

  src_e                  rr_q;

  // Output stage registers
  logic                  out_valid_q;
  logic [ID_WIDTH-1:0]   out_id_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic [4:0]            out_rd_q;
  logic                  out_we_q;
  logic                  out_exc_q;
  logic [5:0]            out_exccode_q;

  // Side-band strobes; independent of x_result backpressure
  logic                  fpr_we_q;
  logic [4:0]            fpr_waddr_q;
  logic [DATA_WIDTH-1:0] fpr_wdata_q;
  logic                  fflags_we_q;
  logic [4:0]            fflags_q;

  logic                  slot_free;
  logic                  grant_fpu;
  logic                  grant_mem;
  logic                  accept_fpu;
  logic                  accept_mem;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  always_comb begin
    // The slot can take a new entry when empty or when its current entry
    // is being handed off to the core this cycle.
    slot_free  = !out_valid_q || x_result_ready_i;

    // Under contention the source that did not win last time goes first.
    grant_fpu  = fpu_valid_i && (!mem_valid_i || (rr_q == SRC_MEM));
    grant_mem  = mem_valid_i && (!fpu_valid_i || (rr_q == SRC_FPU));

    accept_fpu = slot_free && grant_fpu;
    accept_mem = slot_free && grant_mem;
  end

  assign fpu_ready_o = accept_fpu;
  assign mem_ready_o = accept_mem;

  assign busy_o = fpu_valid_i || mem_valid_i || out_valid_q;

  // ---------------------------------------------------------------------------
  // Output stage
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q          <= SRC_FPU;
      out_valid_q   <= 1'b0;
      out_id_q      <= '0;
      out_data_q    <= '0;
      out_rd_q      <= '0;
      out_we_q      <= 1'b0;
      out_exc_q     <= 1'b0;
      out_exccode_q <= '0;
      fpr_we_q      <= 1'b0;
      fpr_waddr_q   <= '0;
      fpr_wdata_q   <= '0;
      fflags_we_q   <= 1'b0;
      fflags_q      <= '0;
    end else begin
      // Strobes last exactly one cycle unless re-armed by a new accept.
      fpr_we_q    <= 1'b0;
      fflags_we_q <= 1'b0;

      if (accept_fpu) begin
        rr_q          <= SRC_FPU;
        out_valid_q   <= 1'b1;
        out_id_q      <= fpu_id_i;
        out_rd_q      <= fpu_rd_i;
        out_exc_q     <= 1'b0;
        out_exccode_q <= '0;
        // fflags are accumulated for every FPU result, even all-zero ones.
        fflags_we_q   <= 1'b1;
        fflags_q      <= fpu_status_i;
        if (fpu_rd_is_fp_i) begin
          // FP destination: result goes to the FP regfile, core only
          // sees a completion.
          out_we_q    <= 1'b0;
          out_data_q  <= '0;
          fpr_we_q    <= 1'b1;
          fpr_waddr_q <= fpu_rd_i;
          fpr_wdata_q <= fpu_result_i;
        end else begin
          // Integer destination (compares, classify, moves to X).
          out_we_q    <= 1'b1;
          out_data_q  <= fpu_result_i;
        end
      end else if (accept_mem) begin
        rr_q        <= SRC_MEM;
        out_valid_q <= 1'b1;
        out_id_q    <= mem_id_i;
        out_rd_q    <= mem_rd_i;
        out_we_q    <= 1'b0;
        out_data_q  <= '0;
        if (mem_err_i) begin
          // Faulting load: no architectural write, report exception.
          out_exc_q     <= 1'b1;
          out_exccode_q <= EXCCODE_LOAD_ACCESS_FAULT;
        end else begin
          out_exc_q     <= 1'b0;
          out_exccode_q <= '0;
          fpr_we_q      <= 1'b1;
          fpr_waddr_q   <= mem_rd_i;
          fpr_wdata_q   <= mem_rdata_i;
        end
      end else if (slot_free) begin
        // Entry handed off (or slot already empty) and nothing new arrives.
        out_valid_q <= 1'b0;
      end
    end
  end

  assign x_result_valid_o   = out_valid_q;
  assign x_result_id_o      = out_id_q;
  assign x_result_data_o    = out_data_q;
  assign x_result_rd_o      = out_rd_q;
  assign x_result_we_o      = out_we_q;
  assign x_result_exc_o     = out_exc_q;
  assign x_result_exccode_o = out_exccode_q;

  assign fpr_we_o    = fpr_we_q;
  assign fpr_waddr_o = fpr_waddr_q;
  assign fpr_wdata_o = fpr_wdata_q;

  assign fflags_we_o = fflags_we_q;
  assign fflags_o    = fflags_q;

endmodule

// File: tb/tb_fpu_ss_wb_arbiter.sv
module tb_fpu_ss_wb_arbiter;

  localparam int IDW = 4;
  localparam int DW  = 32;

  logic           clk_i = 1'b0;
  logic           rst_ni;
  logic           fpu_valid_i;
  logic           fpu_ready_o;
  logic [DW-1:0]  fpu_result_i;
  logic [4:0]     fpu_status_i;
  logic [4:0]     fpu_rd_i;
  logic           fpu_rd_is_fp_i;
  logic [IDW-1:0] fpu_id_i;
  logic           mem_valid_i;
  logic           mem_ready_o;
  logic [DW-1:0]  mem_rdata_i;
  logic [4:0]     mem_rd_i;
  logic [IDW-1:0] mem_id_i;
  logic           mem_err_i;
  logic           fpr_we_o;
  logic [4:0]     fpr_waddr_o;
  logic [DW-1:0]  fpr_wdata_o;
  logic           fflags_we_o;
  logic [4:0]     fflags_o;
  logic           x_result_valid_o;
  logic           x_result_ready_i;
  logic [IDW-1:0] x_result_id_o;
  logic [DW-1:0]  x_result_data_o;
  logic [4:0]     x_result_rd_o;
  logic           x_result_we_o;
  logic           x_result_exc_o;
  logic [5:0]     x_result_exccode_o;
  logic           busy_o;

  fpu_ss_wb_arbiter #(.ID_WIDTH(IDW), .DATA_WIDTH(DW)) dut (
    .clk_i              (clk_i),
    .rst_ni             (rst_ni),
    .fpu_valid_i        (fpu_valid_i),
    .fpu_ready_o        (fpu_ready_o),
    .fpu_result_i       (fpu_result_i),
    .fpu_status_i       (fpu_status_i),
    .fpu_rd_i           (fpu_rd_i),
    .fpu_rd_is_fp_i     (fpu_rd_is_fp_i),
    .fpu_id_i           (fpu_id_i),
    .mem_valid_i        (mem_valid_i),
    .mem_ready_o        (mem_ready_o),
    .mem_rdata_i        (mem_rdata_i),
    .mem_rd_i           (mem_rd_i),
    .mem_id_i           (mem_id_i),
    .mem_err_i          (mem_err_i),
    .fpr_we_o           (fpr_we_o),
    .fpr_waddr_o        (fpr_waddr_o),
    .fpr_wdata_o        (fpr_wdata_o),
    .fflags_we_o        (fflags_we_o),
    .fflags_o           (fflags_o),
    .x_result_valid_o   (x_result_valid_o),
    .x_result_ready_i   (x_result_ready_i),
    .x_result_id_o      (x_result_id_o),
    .x_result_data_o    (x_result_data_o),
    .x_result_rd_o      (x_result_rd_o),
    .x_result_we_o      (x_result_we_o),
    .x_result_exc_o     (x_result_exc_o),
    .x_result_exccode_o (x_result_exccode_o),
    .busy_o             (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: what the core should currently be seeing.
  bit          m_vld;
  logic [3:0]  m_id;
  logic [31:0] m_data;
  logic [4:0]  m_rd;
  bit          m_we;
  bit          m_exc;
  logic [5:0]  m_code;
  bit          m_fpr_we;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  bit          m_ff_we;
  logic [4:0]  m_ff;
  bit          m_last_mem;       // most recent grant went to the load path
  int          m_grant;          // 0 none, 1 fpu, 2 mem (this cycle)
  int unsigned id_q[$];          // ids in acceptance order, not yet completed

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_vld = 0; m_id = 0; m_data = 0; m_rd = 0; m_we = 0; m_exc = 0; m_code = 0;
    m_fpr_we = 0; m_waddr = 0; m_wdata = 0; m_ff_we = 0; m_ff = 0;
    m_last_mem = 0; m_grant = 0;
    id_q.delete();
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_xr_valid"}, x_result_valid_o, 0);
    chk({pfx, "_fpr_we"}, fpr_we_o, 0);
    chk({pfx, "_fflags_we"}, fflags_we_o, 0);
    chk({pfx, "_xr_id"}, x_result_id_o, 0);
    chk({pfx, "_xr_data"}, x_result_data_o, 0);
    chk({pfx, "_xr_rd"}, x_result_rd_o, 0);
    chk({pfx, "_xr_we"}, x_result_we_o, 0);
    chk({pfx, "_xr_exc"}, x_result_exc_o, 0);
    chk({pfx, "_xr_exccode"}, x_result_exccode_o, 0);
    chk({pfx, "_fpr_waddr"}, fpr_waddr_o, 0);
    chk({pfx, "_fpr_wdata"}, fpr_wdata_o, 0);
    chk({pfx, "_fflags"}, fflags_o, 0);
  endtask

  task automatic set_idle();
    fpu_valid_i = 0; fpu_result_i = 0; fpu_status_i = 0; fpu_rd_i = 0;
    fpu_rd_is_fp_i = 0; fpu_id_i = 0;
    mem_valid_i = 0; mem_rdata_i = 0; mem_rd_i = 0; mem_id_i = 0; mem_err_i = 0;
  endtask

  task automatic set_fpu(input bit v, input logic [31:0] res, input logic [4:0] st,
                         input logic [4:0] rd, input bit is_fp, input logic [3:0] id);
    fpu_valid_i = v; fpu_result_i = res; fpu_status_i = st;
    fpu_rd_i = rd; fpu_rd_is_fp_i = is_fp; fpu_id_i = id;
  endtask

  task automatic set_mem(input bit v, input logic [31:0] data, input logic [4:0] rd,
                         input logic [3:0] id, input bit err);
    mem_valid_i = v; mem_rdata_i = data; mem_rd_i = rd; mem_id_i = id; mem_err_i = err;
  endtask

  // One clock cycle, entered and left at a falling edge with inputs already driven.
  task automatic cycle();
    bit free, gf, gm;
    #1;
    free = !m_vld || x_result_ready_i;
    gf = 0; gm = 0;
    if (free) begin
      if (fpu_valid_i && mem_valid_i) begin
        gm = !m_last_mem;
        gf = m_last_mem;
      end else begin
        gf = fpu_valid_i;
        gm = mem_valid_i;
      end
    end
    chk("fpu_ready", fpu_ready_o, gf);
    chk("mem_ready", mem_ready_o, gm);
    chk("busy", busy_o, fpu_valid_i || mem_valid_i || m_vld);
    // A completing handshake must carry the oldest accepted id.
    if (m_vld && x_result_ready_i && id_q.size() > 0)
      chk("order_id", x_result_id_o, id_q.pop_front());

    @(posedge clk_i);
    m_fpr_we = 0;
    m_ff_we  = 0;
    m_grant  = 0;
    if (gf) begin
      m_grant = 1; m_last_mem = 0;
      m_vld = 1; m_id = fpu_id_i; m_rd = fpu_rd_i; m_exc = 0; m_code = 0;
      m_ff_we = 1; m_ff = fpu_status_i;
      if (fpu_rd_is_fp_i) begin
        m_we = 0; m_data = 0;
        m_fpr_we = 1; m_waddr = fpu_rd_i; m_wdata = fpu_result_i;
      end else begin
        m_we = 1; m_data = fpu_result_i;
      end
      id_q.push_back(fpu_id_i);
    end else if (gm) begin
      m_grant = 2; m_last_mem = 1;
      m_vld = 1; m_id = mem_id_i; m_rd = mem_rd_i; m_we = 0; m_data = 0;
      if (mem_err_i) begin
        m_exc = 1; m_code = 6'd5;
      end else begin
        m_exc = 0; m_code = 0;
        m_fpr_we = 1; m_waddr = mem_rd_i; m_wdata = mem_rdata_i;
      end
      id_q.push_back(mem_id_i);
    end else if (free) begin
      m_vld = 0;
    end

    #1;
    chk("xr_valid", x_result_valid_o, m_vld);
    if (m_vld) begin
      chk("xr_id", x_result_id_o, m_id);
      chk("xr_data", x_result_data_o, m_data);
      chk("xr_rd", x_result_rd_o, m_rd);
      chk("xr_we", x_result_we_o, m_we);
      chk("xr_exc", x_result_exc_o, m_exc);
      chk("xr_exccode", x_result_exccode_o, m_code);
    end
    chk("fpr_we", fpr_we_o, m_fpr_we);
    if (m_fpr_we) begin
      chk("fpr_waddr", fpr_waddr_o, m_waddr);
      chk("fpr_wdata", fpr_wdata_o, m_wdata);
    end
    chk("fflags_we", fflags_we_o, m_ff_we);
    if (m_ff_we) chk("fflags", fflags_o, m_ff);
    @(negedge clk_i);
  endtask

  initial begin
    int fpr_pulses;
    int exp_ids[4];
    set_idle();
    x_result_ready_i = 1;
    rst_ni = 0;
    model_reset();
    #3;
    chk_all_zero("reset");
    chk("reset_busy_idle", busy_o, 0);
    fpu_valid_i = 1;
    #1;
    chk("reset_busy_comb", busy_o, 1);
    fpu_valid_i = 0;
    @(negedge clk_i);
    rst_ni = 1;

    // Single FPU op writing an FP register
    set_fpu(1, 32'h3F800000, 5'b00001, 5'd7, 1, 4'd3);
    cycle();
    set_idle();
    chk("tp1_fpr_we", fpr_we_o, 1);
    chk("tp1_fpr_waddr", fpr_waddr_o, 7);
    chk("tp1_fpr_wdata", fpr_wdata_o, 32'h3F800000);
    chk("tp1_fflags", fflags_o, 5'h01);
    chk("tp1_xr_id", x_result_id_o, 3);
    chk("tp1_xr_we", x_result_we_o, 0);
    cycle();

    // FPU op with integer destination (feq)
    set_fpu(1, 32'd1, 5'b00000, 5'd10, 0, 4'd5);
    cycle();
    set_idle();
    chk("tp2_xr_we", x_result_we_o, 1);
    chk("tp2_xr_rd", x_result_rd_o, 10);
    chk("tp2_xr_data", x_result_data_o, 1);
    chk("tp2_fpr_we", fpr_we_o, 0);
    chk("tp2_fflags_we", fflags_we_o, 1);
    cycle();

    // Contention for 4 cycles: mem, fpu, mem, fpu
    exp_ids = '{12, 2, 12, 2};
    set_fpu(1, 32'h40000000, 5'b00010, 5'd3, 1, 4'd2);
    set_mem(1, 32'hCAFEF00D, 5'd4, 4'd12, 0);
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("contend_id", x_result_id_o, exp_ids[i]);
    end
    set_idle();
    cycle();

    // Faulting load
    set_mem(1, 32'hDEADBEEF, 5'd8, 4'd9, 1);
    cycle();
    set_idle();
    chk("tp4_exc", x_result_exc_o, 1);
    chk("tp4_exccode", x_result_exccode_o, 5);
    chk("tp4_id", x_result_id_o, 9);
    chk("tp4_fpr_we", fpr_we_o, 0);
    cycle();

    // Backpressure: first result parks in the slot, second waits
    x_result_ready_i = 0;
    set_fpu(1, 32'h11111111, 5'b00100, 5'd1, 1, 4'd1);
    cycle();
    fpr_pulses = fpr_we_o ? 1 : 0;
    set_fpu(1, 32'h22222222, 5'b01000, 5'd2, 1, 4'd2);
    for (int i = 0; i < 3; i++) begin
      cycle();
      if (fpr_we_o) fpr_pulses++;
      chk("bp_hold_id", x_result_id_o, 1);
      chk("bp_hold_data_rd", x_result_rd_o, 1);
    end
    chk("bp_fpr_pulses", fpr_pulses, 1);
    x_result_ready_i = 1;
    cycle();
    chk("bp_release_id", x_result_id_o, 2);
    set_idle();
    cycle();

    // Reset while a result is pending
    set_fpu(1, 32'h33333333, 5'b10000, 5'd6, 1, 4'd7);
    x_result_ready_i = 0;
    cycle();
    chk("prereset_valid", x_result_valid_o, 1);
    rst_ni = 0;
    #1;
    chk_all_zero("midreset");
    model_reset();
    set_idle();
    x_result_ready_i = 1;
    @(negedge clk_i);
    rst_ni = 1;
    set_fpu(1, 32'h44444444, 5'b00000, 5'd9, 1, 4'd4);
    set_mem(1, 32'h55555555, 5'd11, 4'd14, 0);
    cycle();
    chk("postreset_grant_mem", x_result_id_o, 14);
    set_idle();
    cycle();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      set_fpu($urandom_range(0, 99) < 55, $urandom, 5'($urandom), 5'($urandom),
              1'($urandom), 4'($urandom));
      set_mem($urandom_range(0, 99) < 45, $urandom, 5'($urandom), 4'($urandom),
              $urandom_range(0, 99) < 20);
      x_result_ready_i = $urandom_range(0, 99) < 70;
      cycle();
    end
    set_idle();
    x_result_ready_i = 1;
    cycle();
    cycle();
    chk("drain_empty", x_result_valid_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
